rom_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single-read-port instruction/data ROM between the instruction-fetch port (I) and the data-load port (D). It accepts word-address requests with a valid/grant handshake and drives the ROM read enable and address for the winner. It captures the ROM read data, which the ROM samples on the clock's falling edge, into a per-port response register with a ready/valid return handshake. It also flags accesses beyond the ROM size instead of letting them alias.

---
 rtl/rom_arbiter.sv | 139 +++++++++++++
 tb/tb_rom_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one single-read-port ROM between the instruction-fetch
// port (I, index 0) and the data-load port (D, index 1).
// Optional feature macro: ROM_ARB_RR_EN selects round-robin arbitration;
// when undefined, D has fixed priority over I.
// The ROM samples rom_addr on the falling edge. Its data is captured into a
// per-port one-entry response buffer on the following rising edge.

// Per-port one-entry response buffer {valid, data, err}.
module rom_arb_rsp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gnt,
  input  logic        in_range,
  input  logic        rready,
  input  logic [31:0] rom_rd,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        rerr
);
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t rsp;

  // A grant always wins over a drain, so a drain and a grant in the same
  // cycle refill the buffer back-to-back. Out-of-range reads return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rsp <= '0;
    else if (gnt)                rsp <= '{valid: 1'b1,
                                          data:  in_range ? rom_rd : 32'd0,
                                          err:   !in_range};
    else if (rsp.valid && rready) rsp.valid <= 1'b0;
  end

  assign rvalid = rsp.valid;
  assign rdata  = rsp.data;
  assign rerr   = rsp.err;
endmodule

module rom_arbiter #(
  parameter int WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:2] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  input  logic        i_rready,
  output logic [31:0] i_rdata,
  output logic        i_rerr,
  input  logic        d_req,
  input  logic [31:2] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic [31:0] d_rdata,
  output logic        d_rerr,
  output logic        rom_re,
  output logic [31:2] rom_addr,
  input  logic [31:0] rom_rd
);
  localparam int NUM_PORTS = 2;
  // Full 30-bit compare against the ROM depth, so high addresses never alias.
  localparam logic [29:0] LIMIT = 30'(WORDS);

  logic [NUM_PORTS-1:0]       req, rready, rvalid, rerr, elig, inr, gnt;
  logic [NUM_PORTS-1:0][29:0] addr;
  logic [NUM_PORTS-1:0][31:0] rdata;

  assign req    = {d_req, i_req};
  assign rready = {d_rready, i_rready};
  assign addr   = {d_addr, i_addr};

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      // Eligible when the buffer is empty or draining this cycle.
      assign elig[p] = req[p] && (!rvalid[p] || rready[p]);
      assign inr[p]  = addr[p] < LIMIT;

      rom_arb_rsp u_rsp (
        .clk      (clk),
        .rst_n    (rst_n),
        .gnt      (gnt[p]),
        .in_range (inr[p]),
        .rready   (rready[p]),
        .rom_rd   (rom_rd),
        .rvalid   (rvalid[p]),
        .rdata    (rdata[p]),
        .rerr     (rerr[p])
      );
    end
  endgenerate

`ifdef ROM_ARB_RR_EN
  // Preferred port: 0 = I, 1 = D.
  logic ptr;

  // Round-robin: the preferred port wins a tie; a lone eligible port wins.
  always_comb begin
    gnt = '0;
    if (&elig) gnt[ptr] = 1'b1;
    else       gnt      = elig;
  end

  // After any grant, prefer the port that was not granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[0];
  end
`else
  // Fixed priority, D over I; I can starve under continuous D traffic.
  always_comb begin
    gnt = '0;
    if (elig[1])      gnt[1] = 1'b1;
    else if (elig[0]) gnt[0] = 1'b1;
  end
`endif

  // ROM is only enabled for an in-range winner; the address is zero otherwise.
  always_comb begin
    rom_re   = |(gnt & inr);
    rom_addr = '0;
    if (rom_re) rom_addr = gnt[1] ? addr[1] : addr[0];
  end

  assign i_gnt    = gnt[0];
  assign d_gnt    = gnt[1];
  assign i_rvalid = rvalid[0];
  assign d_rvalid = rvalid[1];
  assign i_rdata  = rdata[0];
  assign d_rdata  = rdata[1];
  assign i_rerr   = rerr[0];
  assign d_rerr   = rerr[1];
endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for contention, backpressure, reset and
// back-to-back reads. Honours ROM_ARB_RR_EN for the contention pattern.
module tb_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, i_rready, d_rready;
  logic [31:2] i_addr, d_addr;
  logic        i_gnt, d_gnt, i_rvalid, d_rvalid, i_rerr, d_rerr, rom_re;
  logic [31:0] i_rdata, d_rdata;
  logic [31:2] rom_addr;
  logic [31:0] rom_rd;

  int checks = 0;
  int errors = 0;

  rom_arbiter #(.WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rready(i_rready), .i_rdata(i_rdata), .i_rerr(i_rerr),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rready(d_rready), .d_rdata(d_rdata), .d_rerr(d_rerr),
    .rom_re(rom_re), .rom_addr(rom_addr), .rom_rd(rom_rd)
  );

  always #5 clk = ~clk;

  // ROM model: word 5 is 0xDEADBEEF, other words 0x1111_0000 + addr.
  // Without rom_re it drives a garbage pattern that must never be captured.
  initial rom_rd = 32'hBAD0_BAD0;
  always @(negedge clk) begin
    if (rom_re) rom_rd <= (rom_addr == 30'd5) ? 32'hDEAD_BEEF : 32'h1111_0000 + 32'(rom_addr);
    else        rom_rd <= 32'hBAD0_BAD0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [29:0] ia, input logic irr,
                       input logic dr, input logic [29:0] da, input logic drr);
    i_req = ir; i_addr = ia; i_rready = irr;
    d_req = dr; d_addr = da; d_rready = drr;
  endtask

  // Inputs are driven at posedge+1; comb outputs are sampled at posedge+4,
  // before the ROM's falling edge; registered outputs at the next posedge+1.
  task automatic to_comb();  #3; endtask
  task automatic to_next();  @(posedge clk); #1; endtask

  typedef struct {
    logic ir; logic [29:0] ia; logic irr;
    logic dr; logic [29:0] da; logic drr;
    logic eig; logic edg; logic ere; logic [29:0] era;
    logic eiv; logic [31:0] eid; logic eie;
    logic edv; logic [31:0] edd; logic ede;
  } vec_t;

  vec_t tbl [12];

  initial begin
    //           ir ia          irr dr da            drr ig dg re ra    iv id            ie dv dd            de
    tbl[0]  = '{1, 30'd5,   1, 0, 30'd0,        1, 1, 0, 1, 30'd5,    1, 32'hDEADBEEF, 0, 0, 32'h0,        0};
    tbl[1]  = '{0, 30'd0,   1, 0, 30'd0,        1, 0, 0, 0, 30'd0,    0, 32'h0,        0, 0, 32'h0,        0};
    tbl[2]  = '{0, 30'd0,   1, 1, 30'd1024,     1, 0, 1, 0, 30'd0,    0, 32'h0,        0, 1, 32'h0,        1};
    tbl[3]  = '{0, 30'd0,   1, 1, 30'd9,        1, 0, 1, 1, 30'd9,    0, 32'h0,        0, 1, 32'h11110009, 0};
    tbl[4]  = '{0, 30'd0,   1, 1, 30'h3FFFFFFF, 1, 0, 1, 0, 30'd0,    0, 32'h0,        0, 1, 32'h0,        1};
    tbl[5]  = '{0, 30'd0,   1, 1, 30'd1023,     1, 0, 1, 1, 30'd1023, 0, 32'h0,        0, 1, 32'h111103FF, 0};
    tbl[6]  = '{0, 30'd0,   1, 1, 30'd1029,     1, 0, 1, 0, 30'd0,    0, 32'h0,        0, 1, 32'h0,        1};
    tbl[7]  = '{0, 30'd0,   1, 0, 30'd0,        1, 0, 0, 0, 30'd0,    0, 32'h0,        0, 0, 32'h0,        0};
    tbl[8]  = '{1, 30'd3,   0, 0, 30'd0,        1, 1, 0, 1, 30'd3,    1, 32'h11110003, 0, 0, 32'h0,        0};
    tbl[9]  = '{1, 30'd4,   0, 1, 30'd6,        1, 0, 1, 1, 30'd6,    1, 32'h11110003, 0, 1, 32'h11110006, 0};
    tbl[10] = '{1, 30'd4,   1, 0, 30'd0,        1, 1, 0, 1, 30'd4,    1, 32'h11110004, 0, 0, 32'h0,        0};
    tbl[11] = '{0, 30'd0,   1, 0, 30'd0,        1, 0, 0, 0, 30'd0,    0, 32'h0,        0, 0, 32'h0,        0};

    // Reset state.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_i_rvalid", 32'(i_rvalid), 0);
    chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_i_rerr", 32'(i_rerr), 0);
    chk("rst_d_rerr", 32'(d_rerr), 0);
    chk("rst_rom_re", 32'(rom_re), 0);
    to_next();
    to_next();
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].ir, tbl[k].ia, tbl[k].irr, tbl[k].dr, tbl[k].da, tbl[k].drr);
      to_comb();
      chk($sformatf("v%0d_i_gnt", k), 32'(i_gnt), 32'(tbl[k].eig));
      chk($sformatf("v%0d_d_gnt", k), 32'(d_gnt), 32'(tbl[k].edg));
      chk($sformatf("v%0d_rom_re", k), 32'(rom_re), 32'(tbl[k].ere));
      chk($sformatf("v%0d_rom_addr", k), 32'(rom_addr), 32'(tbl[k].era));
      to_next();
      chk($sformatf("v%0d_i_rvalid", k), 32'(i_rvalid), 32'(tbl[k].eiv));
      chk($sformatf("v%0d_d_rvalid", k), 32'(d_rvalid), 32'(tbl[k].edv));
      if (tbl[k].eiv) begin
        chk($sformatf("v%0d_i_rdata", k), i_rdata, tbl[k].eid);
        chk($sformatf("v%0d_i_rerr", k), 32'(i_rerr), 32'(tbl[k].eie));
      end
      if (tbl[k].edv) begin
        chk($sformatf("v%0d_d_rdata", k), d_rdata, tbl[k].edd);
        chk($sformatf("v%0d_d_rerr", k), 32'(d_rerr), 32'(tbl[k].ede));
      end
    end

    // Contention right after a reset: I addr 1, D addr 2 for 4 cycles.
    drive(0, 0, 1, 0, 0, 1);
    rst_n = 1'b0;
    to_next();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      logic exp_i;
      drive(1, 30'd1, 1, 1, 30'd2, 1);
`ifdef ROM_ARB_RR_EN
      exp_i = (c % 2 == 0);
`else
      exp_i = 1'b0;
`endif
      to_comb();
      chk($sformatf("cont%0d_i_gnt", c), 32'(i_gnt), 32'(exp_i));
      chk($sformatf("cont%0d_d_gnt", c), 32'(d_gnt), 32'(!exp_i));
      chk($sformatf("cont%0d_rom_addr", c), 32'(rom_addr), exp_i ? 32'd1 : 32'd2);
      to_next();
      if (exp_i) chk($sformatf("cont%0d_i_rdata", c), i_rdata, 32'h11110001);
      else       chk($sformatf("cont%0d_d_rdata", c), d_rdata, 32'h11110002);
    end
    drive(0, 0, 1, 0, 0, 1);
    to_next();

    // Backpressure: I reads addr 3 and then holds rready low for 3 cycles.
    drive(1, 30'd3, 0, 0, 0, 1);
    to_comb();
    chk("bp_first_gnt", 32'(i_gnt), 1);
    to_next();
    i_addr = 30'd8;
    for (int c = 0; c < 3; c++) begin
      to_comb();
      chk($sformatf("bp%0d_no_gnt", c), 32'(i_gnt), 0);
      chk($sformatf("bp%0d_rom_re", c), 32'(rom_re), 0);
      to_next();
      chk($sformatf("bp%0d_rvalid", c), 32'(i_rvalid), 1);
      chk($sformatf("bp%0d_rdata", c), i_rdata, 32'h11110003);
    end
    i_rready = 1'b1;
    to_comb();
    chk("bp_release_gnt", 32'(i_gnt), 1);
    chk("bp_release_addr", 32'(rom_addr), 8);
    to_next();
    chk("bp_new_rvalid", 32'(i_rvalid), 1);
    chk("bp_new_rdata", i_rdata, 32'h11110008);
    drive(0, 0, 1, 0, 0, 1);
    to_next();

    // Reset asserted in the cycle after a grant.
    drive(1, 30'd5, 1, 0, 0, 1);
    to_next();
    drive(0, 0, 1, 0, 0, 1);
    chk("mid_pre_rvalid", 32'(i_rvalid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(i_rvalid), 0);
    chk("mid_rst_rdata", i_rdata, 0);
    to_next();
    rst_n = 1'b1;
    drive(1, 30'd7, 1, 0, 0, 1);
    to_comb();
    chk("mid_after_gnt", 32'(i_gnt), 1);
    to_next();
    drive(0, 0, 1, 0, 0, 1);
    chk("mid_after_rvalid", 32'(i_rvalid), 1);
    chk("mid_after_rdata", i_rdata, 32'h11110007);
    to_next();

    // Back-to-back D reads of addr 0..7 with rready held high.
    for (int a = 0; a < 8; a++) begin
      drive(0, 0, 1, 1, 30'(a), 1);
      to_comb();
      chk($sformatf("b2b%0d_d_gnt", a), 32'(d_gnt), 1);
      to_next();
      chk($sformatf("b2b%0d_rvalid", a), 32'(d_rvalid), 1);
      chk($sformatf("b2b%0d_rdata", a), d_rdata,
          (a == 5) ? 32'hDEADBEEF : 32'h11110000 + 32'(a));
    end
    drive(0, 0, 1, 0, 0, 1);
    to_next();
    chk("b2b_end_rvalid", 32'(d_rvalid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
